// File: rtl/instr_type.sv
`default_nettype none
// ============================================================================
//  Module   : instr_type (package)
//  Purpose  : Shared types for the load unit: load kinds, load exceptions,
//             FSM state encoding and funct3 decode / alignment helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package instr_type;

  // Load flavours; lk_invalid marks a funct3 that is not a legal load for
  // the configured XLEN.
  typedef enum logic [2:0] {
    lk_lb,
    lk_lh,
    lk_lw,
    lk_lbu,
    lk_lhu,
    lk_ld,
    lk_lwu,
    lk_invalid
  } load_kind_t;

  typedef enum logic [1:0] {
    lx_none,
    lx_misaligned,
    lx_illegal
  } load_exc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB,
    S_EXC
  } load_state_t;

  // funct3 -> load kind. LD and LWU only exist on a 64-bit datapath.
  function automatic load_kind_t decode_kind(input logic [2:0] f3, input logic rv64);
    load_kind_t k;
    case (f3)
      3'b000:  k = lk_lb;
      3'b001:  k = lk_lh;
      3'b010:  k = lk_lw;
      3'b100:  k = lk_lbu;
      3'b101:  k = lk_lhu;
      3'b011:  k = rv64 ? lk_ld  : lk_invalid;
      3'b110:  k = rv64 ? lk_lwu : lk_invalid;
      default: k = lk_invalid;
    endcase
    return k;
  endfunction

  // Natural alignment test on the low three address bits.
  function automatic logic is_misaligned(input load_kind_t k, input logic [2:0] a);
    logic m;
    case (k)
      lk_lh, lk_lhu: m = a[0];
      lk_lw, lk_lwu: m = |a[1:0];
      lk_ld:         m = |a;
      default:       m = 1'b0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module   : load_align
//  Purpose  : Combinational extraction of a load result from the full aligned
//             memory word: shift right by the byte offset, then sign- or
//             zero-extend the selected 8/16/32/64 bits to XLEN.
//  Ports    : kind   - load kind (instr_type::load_kind_t)
//             offset - byte offset of the access within the word
//             data   - aligned memory word
//             result - extended load value
//  Revision : 1.0 - initial release
// ============================================================================
module load_align
  import instr_type::*;
#(
  parameter int XLEN = 32,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  load_kind_t        kind,
  input  logic [OFF_W-1:0]  offset,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN-1:0]   result
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = data >> {offset, 3'b000};
    result  = '0;
    case (kind)
      lk_lb:   result = XLEN'($signed(shifted[7:0]));
      lk_lh:   result = XLEN'($signed(shifted[15:0]));
      lk_lw:   result = XLEN'($signed(shifted[31:0]));
      lk_lbu:  result = XLEN'(shifted[7:0]);
      lk_lhu:  result = XLEN'(shifted[15:0]);
      lk_lwu:  result = XLEN'(shifted[31:0]);
      lk_ld:   result = shifted;
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_unit
//  Purpose  : Single-outstanding load unit. Accepts a load request, checks
//             legality and alignment, issues an aligned memory read, extracts
//             and extends the result, and hands it to writeback. Illegal or
//             misaligned loads raise a one-cycle exception instead.
//  Ports    : clk, rst (async, active-low)
//             req_*      - load request (valid/ready, funct3, addr, rd)
//             mem_req_*  - aligned memory read request (valid/ready, addr)
//             mem_resp_* - memory response (valid, full aligned word)
//             wb_*       - writeback (valid/ready, data, rd)
//             exc_*      - exception pulse (valid, cause, faulting addr)
//  Revision : 1.0 - initial release
// ============================================================================
module load_unit
  import instr_type::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [4:0]        req_rd,
  // memory request
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  // memory response
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data,
  // writeback
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [4:0]        wb_rd,
  // exception
  output logic              exc_valid,
  output load_exc_t         exc_cause,
  output logic [ADDR_W-1:0] exc_addr
);

  localparam int OFF_W = $clog2(XLEN / 8);

  load_state_t       state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        rd_q;
  load_kind_t        kind_q;
  load_exc_t         cause_q;
  logic [XLEN-1:0]   result_q;

  load_kind_t        in_kind;
  logic              in_mis;
  logic              accept;
  logic [XLEN-1:0]   align_result;

  assign in_kind = decode_kind(req_funct3, XLEN == 64);
  assign in_mis  = is_misaligned(in_kind, req_addr[2:0]);
  assign accept  = (state == S_IDLE) && req_valid;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // --------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    next_state    = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    wb_valid      = 1'b0;
    exc_valid     = 1'b0;
    exc_cause     = lx_none;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // Illegal kind wins over misalignment; neither touches memory.
          if (in_kind == lk_invalid || in_mis) next_state = S_EXC;
          else                                 next_state = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) next_state = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) next_state = S_WB;
      end
      S_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) next_state = S_IDLE;
      end
      S_EXC: begin
        exc_valid  = 1'b1;
        exc_cause  = cause_q;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      rd_q     <= '0;
      kind_q   <= lk_lb;
      cause_q  <= lx_none;
      result_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        rd_q    <= req_rd;
        kind_q  <= in_kind;
        cause_q <= (in_kind == lk_invalid) ? lx_illegal :
                   in_mis                  ? lx_misaligned : lx_none;
      end
      if (state == S_WAIT && mem_resp_valid) result_q <= align_result;
    end
  end

  load_align #(.XLEN(XLEN)) u_align (
    .kind   (kind_q),
    .offset (addr_q[OFF_W-1:0]),
    .data   (mem_resp_data),
    .result (align_result)
  );

  assign mem_req_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign wb_data      = result_q;
  assign wb_rd        = rd_q;
  assign exc_addr     = addr_q;

endmodule
`default_nettype wire

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, which is the datapath width and SHALL be either 32 or 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, which is the byte-address width.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Request ports SHALL be: req_valid in 1, req_ready out 1, req_funct3 in 3, req_addr in ADDR_W, req_rd in 5 (destination register).
REQ-006 Memory request ports SHALL be: mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out ADDR_W (aligned to XLEN/8 bytes).
REQ-007 Memory response ports SHALL be: mem_resp_valid in 1, mem_resp_data in XLEN (the full aligned word).
REQ-008 Writeback ports SHALL be: wb_valid out 1, wb_ready in 1, wb_data out XLEN, wb_rd out 5.
REQ-009 Exception ports SHALL be: exc_valid out 1, exc_cause out load_exc_t, exc_addr out ADDR_W.

Function
REQ-010 The FSM SHALL have the states S_IDLE, S_REQ, S_WAIT, S_WB and S_EXC, and req_ready SHALL be 1 only in S_IDLE.
REQ-011 On a request handshake, the block SHALL latch funct3, addr and rd, and decode funct3 into load_kind_t as follows:
- 000 -> LB, 001 -> LH, 010 -> LW, 100 -> LBU, 101 -> LHU.
- When XLEN=64: 011 -> LD, 110 -> LWU, 111 -> invalid.
- When XLEN=32: 011, 110 and 111 -> invalid.
REQ-012 Invalid kind SHALL go to S_EXC with cause lx_illegal, and SHALL take priority over misalignment.
REQ-013 Misalignment SHALL go to S_EXC with cause lx_misaligned, defined per kind:
- H/HU: addr[0] != 0.
- W/WU: addr[1:0] != 0.
- D: addr[2:0] != 0.
REQ-014 Any other accepted request SHALL go to S_REQ.
REQ-015 No memory request SHALL be issued for an exception.
REQ-016 S_EXC SHALL drive exc_valid=1 and exc_addr=latched addr for exactly one cycle, then return to S_IDLE.
REQ-017 S_REQ SHALL hold mem_req_valid=1 with mem_req_addr = addr with its low log2(XLEN/8) bits cleared, stable until mem_req_ready=1, then go to S_WAIT.
REQ-018 S_WAIT SHALL stay until mem_resp_valid=1, then capture the extracted result and go to S_WB.
REQ-019 mem_resp_valid outside S_WAIT SHALL be ignored.
REQ-020 Extraction SHALL shift mem_resp_data right by 8*offset, where offset = addr[log2(XLEN/8)-1:0].
REQ-021 After the shift, extraction SHALL take 8/16/32/64 bits and sign-extend (LB/LH/LW/LD) or zero-extend (LBU/LHU/LWU) to XLEN.
REQ-022 LW on XLEN=32 SHALL pass 32 bits unchanged.
REQ-023 S_WB SHALL hold wb_valid=1 with wb_data and wb_rd stable until wb_ready=1, then go to S_IDLE.
REQ-024 A new request SHALL NOT be accepted in the S_WB handshake cycle; the earliest next accept is the following cycle.
REQ-025 Minimum latency SHALL be: accept at T; mem_req_valid at T+1; with mem_req_ready at T+1 and mem_resp_valid at T+2, wb_valid at T+3.
REQ-026 Back-pressure on mem_req_ready or wb_ready SHALL stall indefinitely without loss or change of data.

Reset
REQ-027 While rst=0, the block SHALL be in S_IDLE with:
- req_ready=1.
- mem_req_valid=0, wb_valid=0, exc_valid=0.
- mem_req_addr, wb_data, exc_addr = 0.
- wb_rd=0, exc_cause=lx_none.
REQ-028 Reset asserted mid-operation, in any state, SHALL abort the transaction immediately, with no writeback or exception emitted afterwards.
REQ-029 A memory response arriving after reset release SHALL be ignored per REQ-019.

Structure
REQ-030 Package instr_type SHALL hold the following:
- load_kind_t, extended with lk_ld and lk_lwu.
- load_exc_t {lx_none, lx_misaligned, lx_illegal}.
- The load_state_t FSM enum.
REQ-031 A combinational sub-module load_align SHALL perform extraction and extension.
- Inputs: kind, offset, data.
- Output: XLEN result.
- It is parametrised by XLEN.

Verification
REQ-032 XLEN=32, LB at addr 0x103, mem_resp_data 0x80FF_1234 -> mem_req_addr 0x100, wb_data 0xFFFF_FF80.
REQ-033 XLEN=32, LHU at addr 0x102, data 0x8001_0000 -> wb_data 0x0000_8001; LH at the same address -> 0xFFFF_8001.
REQ-034 XLEN=32, LW at addr 0x102 -> exc_valid for 1 cycle, cause lx_misaligned, exc_addr 0x102, mem_req_valid never 1.
REQ-035 funct3 011 with XLEN=32 -> lx_illegal; with XLEN=64, LD at 0x08 and data 0x8000_0000_0000_0001 -> wb_data equal to the data.
REQ-036 XLEN=64, LWU at 0x0C, data 0xDEAD_BEEF_0000_0000 -> wb_data 0x0000_0000_DEAD_BEEF; LW at the same address -> 0xFFFF_FFFF_DEAD_BEEF.
REQ-037 Reset and back-pressure checks:
- wb_ready held 0 for 5 cycles -> wb_valid and wb_data stable throughout.
- rst=0 pulsed in S_WAIT, then a response -> no wb_valid, req_ready=1.
